// File: rtl/mux6_rr_arbiter.sv
// rtl/mux6_rr_arbiter.sv - round-robin arbiter sharing one 4-bit channel among six requesters
module mux6_rr_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [5:0] req,
    input  logic [3:0] data0,
    input  logic [3:0] data1,
    input  logic [3:0] data2,
    input  logic [3:0] data3,
    input  logic [3:0] data4,
    input  logic [3:0] data5,
    output logic [3:0] out,
    output logic       out_valid,
    output logic [5:0] gnt,
    output logic [2:0] sel
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    ptr;
    logic [2:0]    ptr_nxt;
    logic [2:0]    own_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          win_found;
    logic [2:0]    win;
    logic [3:0]    data_nxt;

    // Scan req starting at ptr; descending loop so the lowest offset wins last.
    always_comb begin
        int s;
        s         = 0;
        win_found = 1'b0;
        win       = 3'd0;
        for (int k = 5; k >= 0; k--) begin
            s = int'(ptr) + k;
            if (s >= 6) begin
                s = s - 6;
            end
            if (req[3'(s)]) begin
                win_found = 1'b1;
                win       = 3'(s);
            end
        end
    end

    // Next-state owner, burst counter and pointer; the owner itself lives in sel.
    always_comb begin
        state_nxt = state;
        own_nxt   = sel;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt = BUSY;
                    own_nxt   = win;
                    cnt_nxt   = ONE;
                    ptr_nxt   = (win == 3'd5) ? 3'd0 : win + 3'd1;
                end
            end
            BUSY: begin
                if (req[sel] && (cnt < MAXC)) begin
                    cnt_nxt = cnt + ONE;
                end else if (win_found) begin
                    // ptr already points past the owner, so a lone owner is re-granted here.
                    own_nxt = win;
                    cnt_nxt = ONE;
                    ptr_nxt = (win == 3'd5) ? 3'd0 : win + 3'd1;
                end else begin
                    state_nxt = IDLE;
                    own_nxt   = 3'd0;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                own_nxt   = 3'd0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Payload of the next owner, sampled into out on the same edge as the grant.
    always_comb begin
        case (own_nxt)
            3'd0:    data_nxt = data0;
            3'd1:    data_nxt = data1;
            3'd2:    data_nxt = data2;
            3'd3:    data_nxt = data3;
            3'd4:    data_nxt = data4;
            3'd5:    data_nxt = data5;
            default: data_nxt = 4'd0;
        endcase
    end

    // State and registered channel outputs, all cleared immediately on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            cnt       <= '0;
            sel       <= 3'd0;
            gnt       <= 6'd0;
            out       <= 4'd0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            if (state_nxt == BUSY) begin
                sel       <= own_nxt;
                gnt       <= 6'd1 << own_nxt;
                out       <= data_nxt;
                out_valid <= 1'b1;
            end else begin
                sel       <= 3'd0;
                gnt       <= 6'd0;
                out       <= 4'd0;
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux6_rr_arbiter.sv
// tb/tb_mux6_rr_arbiter.sv - scoreboard bench for mux6_rr_arbiter at MAX_BURST 4 and 1
module tb_mux6_rr_arbiter;

    logic       clk = 1'b0;
    logic       resetn;
    logic [5:0] req;
    logic [3:0] dv [6];

    logic [3:0] out0, out1;
    logic       ov0, ov1;
    logic [5:0] gnt0, gnt1;
    logic [2:0] sel0, sel1;

    typedef struct {
        int          u;
        logic [13:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_owner [2];
    int   m_ptr   [2];
    int   m_cnt   [2];
    int   mb      [2] = '{4, 1};

    always #5 clk = ~clk;

    mux6_rr_arbiter #(.MAX_BURST(4)) u_dut (
        .clk(clk), .resetn(resetn), .req(req),
        .data0(dv[0]), .data1(dv[1]), .data2(dv[2]),
        .data3(dv[3]), .data4(dv[4]), .data5(dv[5]),
        .out(out0), .out_valid(ov0), .gnt(gnt0), .sel(sel0)
    );

    mux6_rr_arbiter #(.MAX_BURST(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .req(req),
        .data0(dv[0]), .data1(dv[1]), .data2(dv[2]),
        .data3(dv[3]), .data4(dv[4]), .data5(dv[5]),
        .out(out1), .out_valid(ov1), .gnt(gnt1), .sel(sel1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_owner[u] = -1;
            m_ptr[u]   = 0;
            m_cnt[u]   = 0;
        end
        sb.delete();
    endtask

    task automatic model_step(input int u, input logic [5:0] r);
        int   f;
        exp_t e;
        if (m_owner[u] >= 0 && r[m_owner[u]] && m_cnt[u] < mb[u]) begin
            m_cnt[u]++;
        end else begin
            f = -1;
            for (int k = 0; k < 6; k++) begin
                int j;
                j = (m_ptr[u] + k) % 6;
                if (f < 0 && r[j]) f = j;
            end
            if (f >= 0) begin
                m_owner[u] = f;
                m_cnt[u]   = 1;
                m_ptr[u]   = (f + 1) % 6;
            end else begin
                m_owner[u] = -1;
                m_cnt[u]   = 0;
            end
        end
        e.u = u;
        if (m_owner[u] >= 0)
            e.v = {1'b1, 6'(1 << m_owner[u]), 3'(m_owner[u]), dv[m_owner[u]]};
        else
            e.v = 14'd0;
        sb.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out"},   out0, 0);
        check({tag, "_valid"}, ov0,  0);
        check({tag, "_gnt"},   gnt0, 0);
        check({tag, "_sel"},   sel0, 0);
        check({tag, "_gnt1"},  gnt1, 0);
    endtask

    // Drive one cycle of stimulus, predict both DUTs, then compare after the edge.
    task automatic step(input logic [5:0] r, input bit rnd);
        exp_t        e;
        logic [13:0] a;
        @(negedge clk);
        req = r;
        if (rnd) for (int i = 0; i < 6; i++) dv[i] = 4'($urandom_range(0, 15));
        model_step(0, r);
        model_step(1, r);
        @(posedge clk);
        #1;
        for (int n = 0; n < 2; n++) begin
            if (sb.size() == 0) begin
                check("sb_size", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                a = (e.u == 0) ? {ov0, gnt0, sel0, out0} : {ov1, gnt1, sel1, out1};
                check($sformatf("u%0d_valid", e.u), a[13],    e.v[13]);
                check($sformatf("u%0d_gnt",   e.u), a[12:7],  e.v[12:7]);
                check($sformatf("u%0d_sel",   e.u), a[6:4],   e.v[6:4]);
                check($sformatf("u%0d_out",   e.u), a[3:0],   e.v[3:0]);
            end
        end
        check("u0_cnt", u_dut.cnt, m_cnt[0]);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear before the next edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        req    = 6'd0;
        resetn = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        #2;
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        req    = 6'd0;
        for (int i = 0; i < 6; i++) dv[i] = 4'd0;
        model_reset();
        #2;
        check_zero("rst");
        @(negedge clk);
        resetn = 1'b1;

        // Single request and release.
        dv[2] = 4'hA;
        step(6'b000100, 1'b0);
        check("t1_sel",   sel0, 2);
        check("t1_gnt",   gnt0, 6'b000100);
        check("t1_out",   out0, 4'hA);
        check("t1_valid", ov0,  1);
        step(6'b000000, 1'b0);
        check("t1_rel_valid", ov0,  0);
        check("t1_rel_out",   out0, 0);

        // Everyone requesting: bursts of four, wrapping after requester 5.
        do_reset("t2rst");
        for (int t = 0; t < 30; t++) begin
            step(6'b111111, 1'b1);
            check("t2_owner", sel0, (t / 4) % 6);
            check("t2_valid", ov0, 1);
        end

        // Early release by 1 hands over to 4; ptr then favours 1.
        do_reset("t3rst");
        step(6'b010010, 1'b1);
        step(6'b010010, 1'b1);
        check("t3_own1", sel0, 1);
        step(6'b010000, 1'b1);
        check("t3_own4", sel0, 4);
        check("t3_cnt",  u_dut.cnt, 1);
        step(6'b010000, 1'b1);
        step(6'b010000, 1'b1);
        step(6'b000010, 1'b1);
        check("t3_regrant1", sel0, 1);
        step(6'b000000, 1'b0);

        // Sole requester keeps the channel across burst boundaries.
        do_reset("t4rst");
        for (int t = 0; t < 10; t++) begin
            step(6'b001000, 1'b1);
            check("t4_gnt",   gnt0, 6'b001000);
            check("t4_valid", ov0, 1);
            check("t4_cnt",   u_dut.cnt, (t % 4) + 1);
        end

        // Reset in the middle of requester 5's burst.
        do_reset("t5rst");
        step(6'b100000, 1'b1);
        step(6'b100000, 1'b1);
        check("t5_sel", sel0, 5);
        check("t5_cnt", u_dut.cnt, 2);
        do_reset("t5mid");
        step(6'b100001, 1'b1);
        check("t5_win0_sel", sel0, 0);
        check("t5_win0_gnt", gnt0, 6'b000001);

        // Per-cycle round robin with moving data.
        do_reset("t6rst");
        for (int t = 0; t < 6; t++) begin
            step(6'b000011, 1'b1);
            check("t6_owner", sel1, t % 2);
            check("t6_data",  out1, dv[t % 2]);
        end

        // Random traffic against the model.
        for (int t = 0; t < 60; t++) begin
            step(6'($urandom_range(0, 63)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux6_rr_arbiter.md
# mux6_rr_arbiter

Round-robin arbiter that shares one 4-bit output channel among six requesters. Each cycle it decides which requester owns the channel and drives the 6-to-1 selection (`sel`). It registers the selected requester's data onto `out`. Ownership lasts up to `MAX_BURST` consecutive cycles, so no requester can starve the others. It sits directly in front of the shared 4-bit datapath and replaces the free-running `sel` source with a fair, sequenced one.

## Interface
- `MAX_BURST`, default 4: maximum consecutive cycles one requester may own the channel. Legal range is 1..15; 1 gives pure per-cycle round robin.

- `clk` input 1: single clock, rising edge.
- `resetn` input 1: reset, asynchronous and active-low.
- `req` input 6: `req[i]` high means requester i wants the channel.
- `data0`..`data5` input 4 each: payload of requester 0..5.
- `out` output 4: registered payload of the current owner; 4'b0 when not valid.
- `out_valid` output 1: `out` carries a granted requester's data this cycle.
- `gnt` output 6: one-hot current owner; 6'b0 when idle.
- `sel` output 3: binary index of the owner, 0..5. It is 3'd0 when idle; 6 and 7 are never driven.

## Operation
- States:
  - IDLE: no owner.
  - BUSY: owner `o` in `sel`, burst counter `cnt` in 1..`MAX_BURST`.
- Round-robin pointer `ptr` is 0..5. Arbitration picks the first asserted `req` bit scanning `ptr`, `ptr+1`, … mod 6 (5 wraps to 0). After every new grant to winner `w`, `ptr` becomes (w+1) mod 6.
- IDLE:
  - If `req`==0, stay in IDLE.
  - Otherwise arbitrate, grant winner `w`, set `cnt`=1, go to BUSY.
- BUSY with owner `o`:
  - If `req[o]`=1 and `cnt` < `MAX_BURST`: keep `o`, increment `cnt`.
  - Otherwise (owner released, or burst exhausted): re-arbitrate from `ptr`, which already equals o+1.
    - If a winner exists, switch to it with no idle cycle and set `cnt`=1. If `o` is the only requester, `o` is re-granted with `cnt`=1.
    - If there is no winner, go to IDLE.
- Output registers, updated every edge from the next-state owner `n`:
  - `sel` <= n, `gnt` <= one-hot(n), `out` <= data_n, `out_valid` <= 1.
  - When the next state is IDLE: `sel`=0, `gnt`=0, `out`=0, `out_valid`=0.
- `out` follows the owner's data every BUSY cycle, not just at grant time.
- `cnt` is `$clog2(MAX_BURST+1)` bits wide and never exceeds `MAX_BURST`.
- Invariants:
  - `gnt` is always one-hot or zero.
  - `out_valid` == |`gnt`.
  - `gnt[sel]` == `out_valid`.

## Timing
- Reset (`resetn`=0, asynchronous, any time including mid-burst):
  - State is IDLE, `ptr`=0, `cnt`=0.
  - `out`=4'b0, `out_valid`=0, `gnt`=6'b0, `sel`=3'd0, all immediately.
  - The first edge after `resetn` rises arbitrates normally.
- Grant latency: `req` sampled at edge k produces `gnt`, `sel`, `out`, `out_valid` valid after edge k (one cycle).
- Release latency: `req[o]` low at edge k means `o` loses `gnt` after edge k. The new owner, if any, is visible in the same cycle.
- Data latency: `data_n` at edge k appears on `out` after edge k.
- Maximum contiguous ownership is `MAX_BURST` cycles while others request.
- Worst-case wait for a continuously requesting input is 5×`MAX_BURST` cycles.
- Simultaneous requests are resolved by `ptr` alone, with no fixed priority beyond it.

## Test plan
- Reset then single request:
  - Stimulus: `resetn` low then high; `req`=6'b000100, `data2`=4'hA.
  - Required: after the first edge, `sel`=2, `gnt`=6'b000100, `out`=4'hA, `out_valid`=1.
  - Required: after `req` drops, `out_valid`=0 and `out`=0 one edge later.
- All requesting, `MAX_BURST`=4:
  - Stimulus: `req`=6'b111111 held for 30 cycles.
  - Required: owners go 0,0,0,0,1,1,1,1,…,5,5,5,5, then 0 again (wrap). There is never an idle cycle.
- Early release:
  - Stimulus: requesters 1 and 4 active; 1 drops `req` after 2 cycles.
  - Required: `gnt` moves to 4 on the next edge with `cnt` restarted. After 4 finishes, `ptr`=5, so 1 is re-granted when it requests.
- Sole requester exhausting burst:
  - Stimulus: only `req[3]` high for 10 cycles.
  - Required: `gnt` stays 6'b001000 continuously, `out_valid` never drops, and `cnt` cycles 1..4.
- Mid-burst async reset:
  - Stimulus: `resetn` pulsed low between edges while owner is 5 with `cnt`=2.
  - Required: all outputs are 0 immediately. After release with `req`=6'b100001, requester 0 wins (`ptr`=0).
- `MAX_BURST`=1 and data tracking:
  - Stimulus: `req`=6'b000011; `data0` and `data1` change every cycle.
  - Required: grants alternate 0,1,0,1. `out` equals the owner's data sampled at the preceding edge.
